// File: rtl/cache_pkg.sv
// Shared cache definitions: address layout, size helpers and tree-PLRU functions.
// Used by the replacement unit, its PLRU sub-module and the cache controller.
package cache_pkg;

    localparam int NUM_SETS_DEF = 16;
    localparam int NUM_WAYS_DEF = 4;
    localparam int SetSize      = $clog2(NUM_SETS_DEF);
    localparam int WaySize      = $clog2(NUM_WAYS_DEF);

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = ADDR_W - SetSize - OFFSET_W;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [SetSize-1:0]  set;
        logic [OFFSET_W-1:0] offset;
    } cache_addr_t;

    // Functions work on a vector sized for the largest supported tree;
    // callers zero-extend their PLRU vector and truncate the result.
    localparam int MAX_WAYS = 64;
    localparam int MAX_LVL  = $clog2(MAX_WAYS);
    localparam int PLRU_MAX = MAX_WAYS - 1;

    function automatic logic [MAX_LVL-1:0] plru_victim(
        input logic [PLRU_MAX-1:0] plru,
        input int                  num_ways
    );
        int node;
        node = 0;
        for (int l = 0; l < MAX_LVL; l++) begin
            if (node < num_ways - 1)
                node = plru[node] ? 2 * node + 2 : 2 * node + 1;
        end
        return MAX_LVL'(node - (num_ways - 1));
    endfunction

    // Walk from the leaf up to the root, pointing every node away from it.
    function automatic logic [PLRU_MAX-1:0] plru_touch(
        input logic [PLRU_MAX-1:0] plru,
        input int                  way,
        input int                  num_ways
    );
        logic [PLRU_MAX-1:0] r;
        int node;
        int parent;
        r    = plru;
        node = way + num_ways - 1;
        for (int l = 0; l < MAX_LVL; l++) begin
            if (node > 0) begin
                parent    = (node - 1) / 2;
                r[parent] = (node == 2 * parent + 1);
                node      = parent;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU for one set: victim way and next state after a touch.
// Ports: plru (current tree bits), way (accessed way) -> victim, next_plru.
module plru_tree
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int WW       = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] plru,
    input  logic [WW-1:0]       way,
    output logic [WW-1:0]       victim,
    output logic [NUM_WAYS-2:0] next_plru
);

    logic [PLRU_MAX-1:0] wide;
    logic [MAX_LVL-1:0]  v_full;
    logic [PLRU_MAX-1:0] t_full;

    always_comb begin
        wide      = PLRU_MAX'(plru);
        v_full    = plru_victim(wide, NUM_WAYS);
        t_full    = plru_touch(wide, int'(way), NUM_WAYS);
        victim    = WW'(v_full);
        next_plru = (NUM_WAYS - 1)'(t_full);
    end

endmodule

// File: rtl/cache_replacement_unit.sv
// Per-set valid bitmap and tree-PLRU state feeding the cache controller.
// Ports: set/hit/fill/invalidate_all in; populated, populate_way, replace_way, valid_mask out.
module cache_replacement_unit
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_SETS)-1:0] set,
    input  logic                        hit,
    input  logic [$clog2(NUM_WAYS)-1:0] hit_way,
    input  logic                        fill,
    input  logic [$clog2(NUM_WAYS)-1:0] fill_way,
    input  logic                        cru_enable,
    input  logic                        invalidate_all,
    output logic                        populated,
    output logic [$clog2(NUM_WAYS)-1:0] populate_way,
    output logic [$clog2(NUM_WAYS)-1:0] replace_way,
    output logic [NUM_WAYS-1:0]         valid_mask
);

    localparam int WW = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

    logic [WW-1:0]       access_way;
    logic [NUM_WAYS-2:0] next_plru;

    // A fill owns the touch; a coincident hit is dropped.
    assign access_way = fill ? fill_way : hit_way;

    plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .plru      (plru_q[set]),
        .way       (access_way),
        .victim    (replace_way),
        .next_plru (next_plru)
    );

    assign valid_mask = valid_q[set];
    assign populated  = &valid_mask;

    always_comb begin
        populate_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_mask[i])
                populate_way = WW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (invalidate_all) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (fill)
                valid_q[set][fill_way] <= 1'b1;
            if (fill || hit)
                plru_q[set] <= next_plru;
        end
    end

    // Controller protocol checks; no functional effect.
    always @(posedge clk) begin
        if (rst_n && !invalidate_all) begin
            assert (!(fill && cru_enable) || populated)
                else $error("replacement fill into non-full set");
            assert (!hit || valid_mask[hit_way])
                else $error("hit on invalid way");
        end
    end

endmodule

// File: tb/tb_cache_replacement_unit.sv
// Directed self-checking bench for cache_replacement_unit.
// Linear steps; expected values hand-derived from the PLRU tree rules.
module tb_cache_replacement_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] set;
    logic       hit;
    logic [1:0] hit_way;
    logic       fill;
    logic [1:0] fill_way;
    logic       cru_enable;
    logic       invalidate_all;
    logic       populated;
    logic [1:0] populate_way;
    logic [1:0] replace_way;
    logic [3:0] valid_mask;

    int n_chk;
    int n_fail;

    cache_replacement_unit #(
        .NUM_SETS (16),
        .NUM_WAYS (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .set            (set),
        .hit            (hit),
        .hit_way        (hit_way),
        .fill           (fill),
        .fill_way       (fill_way),
        .cru_enable     (cru_enable),
        .invalidate_all (invalidate_all),
        .populated      (populated),
        .populate_way   (populate_way),
        .replace_way    (replace_way),
        .valid_mask     (valid_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        set            = 4'd3;
        hit            = 1'b0;
        hit_way        = 2'd0;
        fill           = 1'b0;
        fill_way       = 2'd0;
        cru_enable     = 1'b0;
        invalidate_all = 1'b0;
        #12;
        chk("init_populated", 32'(populated), 32'd0);
        chk("init_valid", 32'(valid_mask), 32'd0);
        rst_n = 1'b1;

        // Put some state in set 2 so reset has something to clear.
        set      = 4'd2;
        fill     = 1'b1;
        fill_way = 2'd0;
        tick();
        fill = 1'b0;
        chk("s2_valid", 32'(valid_mask), 32'h1);
        chk("s2_replace", 32'(replace_way), 32'd2);
        chk("s2_popway", 32'(populate_way), 32'd1);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_mask), 32'd0);
        chk("arst_replace", 32'(replace_way), 32'd0);
        chk("arst_popway", 32'(populate_way), 32'd0);
        chk("arst_populated", 32'(populated), 32'd0);
        set = 4'd3;
        #1;
        chk("arst_s3_populated", 32'(populated), 32'd0);
        chk("arst_s3_popway", 32'(populate_way), 32'd0);
        chk("arst_s3_replace", 32'(replace_way), 32'd0);
        rst_n = 1'b1;

        // Fill set 5 ways 0..3.
        set      = 4'd5;
        fill     = 1'b1;
        fill_way = 2'd0;
        tick();
        chk("fill0_popway", 32'(populate_way), 32'd1);
        fill_way = 2'd1;
        tick();
        chk("fill1_popway", 32'(populate_way), 32'd2);
        fill_way = 2'd2;
        tick();
        chk("fill2_popway", 32'(populate_way), 32'd3);
        chk("fill2_populated", 32'(populated), 32'd0);
        fill_way = 2'd3;
        tick();
        fill = 1'b0;
        chk("fill3_populated", 32'(populated), 32'd1);
        chk("fill3_valid", 32'(valid_mask), 32'hf);
        chk("fill3_replace", 32'(replace_way), 32'd0);
        chk("fill3_popway", 32'(populate_way), 32'd0);

        // Hit way 0: tree becomes b0=1 b1=1 b2=0.
        hit     = 1'b1;
        hit_way = 2'd0;
        tick();
        hit = 1'b0;
        chk("hit0_replace", 32'(replace_way), 32'd2);

        // Fill and hit together: only the fill of way 3 touches.
        hit        = 1'b1;
        hit_way    = 2'd1;
        fill       = 1'b1;
        fill_way   = 2'd3;
        cru_enable = 1'b1;
        tick();
        hit        = 1'b0;
        fill       = 1'b0;
        cru_enable = 1'b0;
        chk("fillhit_replace", 32'(replace_way), 32'd1);
        chk("fillhit_valid", 32'(valid_mask), 32'hf);

        // Other sets untouched.
        set = 4'd6;
        #1;
        chk("s6_populated", 32'(populated), 32'd0);
        chk("s6_valid", 32'(valid_mask), 32'd0);
        chk("s6_replace", 32'(replace_way), 32'd0);
        set = 4'd2;
        #1;
        chk("s2_after_reset", 32'(valid_mask), 32'd0);

        // Invalidate wins over a coincident fill.
        set            = 4'd5;
        invalidate_all = 1'b1;
        fill           = 1'b1;
        fill_way       = 2'd2;
        tick();
        invalidate_all = 1'b0;
        fill           = 1'b0;
        chk("inv_valid", 32'(valid_mask), 32'd0);
        chk("inv_populated", 32'(populated), 32'd0);
        chk("inv_replace", 32'(replace_way), 32'd0);
        chk("inv_popway", 32'(populate_way), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
